// File: rtl/pit_multi_chan_pkg.sv
// pit_pkg: shared definitions for the multi-channel programmable interrupt timer.
//   - Register offsets within a channel's 4-word window.
//   - CTRL register bit positions.
//   - pit_ctrl_t: the software-visible control fields of one channel.
//   - prescale_tick(): prescaler terminal-count detect.
package pit_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_MOD    = 2'd1;
  localparam logic [1:0] REG_CNT    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_IEN_BIT     = 1;
  localparam int unsigned CTRL_ONESHOT_BIT = 2;
  localparam int unsigned CTRL_PRE_LSB     = 8;
  localparam int unsigned CTRL_PRE_MSB     = 11;
  localparam int unsigned CTRL_FLAG_BIT    = 15;

  localparam int unsigned PRESCALE_W = 15;

  typedef struct packed {
    logic       en;
    logic       ien;
    logic       oneshot;
    logic [3:0] pre;
  } pit_ctrl_t;

  // Tick when the low 'pre' bits of the prescaler are all ones; pre=0 ticks every cycle.
  function automatic logic prescale_tick(input logic [PRESCALE_W-1:0] cnt,
                                         input logic [3:0]            pre);
    logic [15:0]           mask16;
    logic [PRESCALE_W-1:0] mask;
    mask16 = (16'd1 << pre) - 16'd1;
    mask   = mask16[PRESCALE_W-1:0];
    return &(cnt | ~mask);
  endfunction

endpackage

// File: rtl/pit_multi_chan_if.sv
// pit_multi_chan_if: single-cycle strobe register bus of the interrupt timer.
//   bus_wr / bus_rd : one-cycle access strobes
//   bus_addr        : {channel, reg[1:0]}
//   bus_wdata       : write data
//   bus_rdata       : registered read data
//   bus_rvalid      : one-cycle read-data-valid pulse
// master drives the strobes (bus adapter / testbench), slave is the timer.
interface pit_multi_chan_if #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 4
);

  logic              bus_wr;
  logic              bus_rd;
  logic [AWIDTH-1:0] bus_addr;
  logic [DWIDTH-1:0] bus_wdata;
  logic [DWIDTH-1:0] bus_rdata;
  logic              bus_rvalid;

  modport master (
    output bus_wr,
    output bus_rd,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_rvalid
  );

  modport slave (
    input  bus_wr,
    input  bus_rd,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_rvalid
  );

endinterface

// File: rtl/pit_multi_chan_chan_core.sv
// pit_chan_core: one timer channel -- CTRL/MOD storage, prescaler, modulo counter,
// wrap detect and rollover flag.
//   i_clk, i_rst_n, i_sync_reset : clock, async active-low reset, sync reset
//   i_ctrl_we / i_ctrl_wdata     : CTRL write strobe and decoded fields
//   i_mod_we / i_mod_wdata       : MOD write strobe and value
//   i_flag_clr                   : write-1-to-clear request for FLAG
//   o_ctrl, o_mod, o_cnt, o_flag : current register state
module pit_chan_core
  import pit_pkg::*;
#(
  parameter int unsigned COUNT_SIZE  = 16,
  parameter bit          NO_PRESCALE = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sync_reset,
  input  logic                  i_ctrl_we,
  input  pit_ctrl_t             i_ctrl_wdata,
  input  logic                  i_mod_we,
  input  logic [COUNT_SIZE-1:0] i_mod_wdata,
  input  logic                  i_flag_clr,
  output pit_ctrl_t             o_ctrl,
  output logic [COUNT_SIZE-1:0] o_mod,
  output logic [COUNT_SIZE-1:0] o_cnt,
  output logic                  o_flag
);

  pit_ctrl_t             r_ctrl, w_ctrl_d, w_ctrl_wr;
  logic [PRESCALE_W-1:0] r_pre, w_pre_d;
  logic [COUNT_SIZE-1:0] r_mod, r_cnt, w_cnt_d, w_mod_m1;
  logic                  r_flag, w_flag_d;
  logic                  w_en_rise, w_tick, w_wrap;

  always_comb begin
    w_ctrl_wr = i_ctrl_wdata;
    if (NO_PRESCALE) w_ctrl_wr.pre = '0;
  end

  assign w_en_rise = i_ctrl_we & w_ctrl_wr.en & ~r_ctrl.en;
  assign w_tick    = r_ctrl.en & (NO_PRESCALE ? 1'b1 : prescale_tick(r_pre, r_ctrl.pre));
  // A zero modulus gives all-ones here, so the counter wraps at 2^COUNT_SIZE-1.
  assign w_mod_m1  = r_mod - COUNT_SIZE'(1);
  // '>=' rather than '==' so a MOD lowered below the running count wraps on the next tick.
  assign w_wrap    = w_tick & (r_cnt >= w_mod_m1);

  always_comb begin
    w_ctrl_d = r_ctrl;
    w_pre_d  = r_pre;
    w_cnt_d  = r_cnt;
    if (r_ctrl.en) w_pre_d = r_pre + PRESCALE_W'(1);
    if (w_tick)    w_cnt_d = w_wrap ? '0 : r_cnt + COUNT_SIZE'(1);
    if (w_wrap && r_ctrl.oneshot) w_ctrl_d.en = 1'b0;
    // A software CTRL write in the same cycle overrides the one-shot auto-disable.
    if (i_ctrl_we) w_ctrl_d = w_ctrl_wr;
    if (w_en_rise) begin
      w_cnt_d = '0;
      w_pre_d = '0;
    end
    // Wrap beats a simultaneous W1C.
    w_flag_d = w_wrap | (r_flag & ~i_flag_clr);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ctrl <= '0;
      r_pre  <= '0;
      r_mod  <= '0;
      r_cnt  <= '0;
      r_flag <= 1'b0;
    end else if (i_sync_reset) begin
      r_ctrl <= '0;
      r_pre  <= '0;
      r_mod  <= '0;
      r_cnt  <= '0;
      r_flag <= 1'b0;
    end else begin
      r_ctrl <= w_ctrl_d;
      r_pre  <= w_pre_d;
      r_cnt  <= w_cnt_d;
      r_flag <= w_flag_d;
      if (i_mod_we) r_mod <= i_mod_wdata;
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_mod  = r_mod;
  assign o_cnt  = r_cnt;
  assign o_flag = r_flag;

endmodule

// File: rtl/pit_multi_chan.sv
// pit_multi_chan: N-channel programmable interrupt timer.
//   bus_clk     : single clock for bus and counters
//   async_rst_b : asynchronous active-low reset
//   sync_reset  : synchronous reset with the same effect
//   bus         : pit_multi_chan_if.slave register port, address {channel, reg[1:0]}
//   irq_o       : registered per-channel interrupt (FLAG & IEN)
//   irq_any_o   : OR of irq_o
// Optional macro PIT_CNT_READBACK_EN: when defined, reg 2 (CNT) returns the live
// counter value; otherwise it reads 0 and no counter read path is built.
module pit_multi_chan
  import pit_pkg::*;
#(
  parameter int unsigned NUM_CHAN    = 4,
  parameter int unsigned COUNT_SIZE  = 16,
  parameter int unsigned DWIDTH      = 32,
  parameter bit          NO_PRESCALE = 1'b0,
  localparam int unsigned AWIDTH     = $clog2(NUM_CHAN) + 2
) (
  input  logic                bus_clk,
  input  logic                async_rst_b,
  input  logic                sync_reset,
  pit_multi_chan_if.slave     bus,
  output logic [NUM_CHAN-1:0] irq_o,
  output logic                irq_any_o
);

  if (NUM_CHAN < 1 || NUM_CHAN > 8) begin : g_bad_num_chan
    $error("pit_multi_chan: NUM_CHAN must be 1..8");
  end
  if (DWIDTH != 16 && DWIDTH != 32) begin : g_bad_dwidth
    $error("pit_multi_chan: DWIDTH must be 16 or 32");
  end
  if (COUNT_SIZE < 2 || COUNT_SIZE > DWIDTH) begin : g_bad_count_size
    $error("pit_multi_chan: COUNT_SIZE must be 2..DWIDTH");
  end

  logic [1:0]            w_reg;
  logic [AWIDTH-1:0]     w_chan;
  logic                  w_chan_ok;
  logic                  w_status_we;
  pit_ctrl_t             w_ctrl_wdata;
  logic [COUNT_SIZE-1:0] w_mod_wdata;
  logic                  w_unused_wdata;

  pit_ctrl_t             w_ctrl [NUM_CHAN];
  logic [COUNT_SIZE-1:0] w_mod  [NUM_CHAN];
  logic [COUNT_SIZE-1:0] w_cnt  [NUM_CHAN];
  logic [NUM_CHAN-1:0]   w_flag, w_sel, w_ctrl_we, w_mod_we, w_flag_clr, w_irq_d;
  logic [DWIDTH-1:0]     w_rd_chain [NUM_CHAN+1];

  logic [DWIDTH-1:0]     r_rdata;
  logic                  r_rvalid;
  logic [NUM_CHAN-1:0]   r_irq;

  assign w_reg       = bus.bus_addr[1:0];
  assign w_chan      = bus.bus_addr >> 2;
  assign w_chan_ok   = (w_chan < AWIDTH'(NUM_CHAN));
  assign w_status_we = bus.bus_wr & w_chan_ok & (w_reg == REG_STATUS);
  assign w_mod_wdata = bus.bus_wdata[COUNT_SIZE-1:0];
  // Only some data bits are decoded; the rest are intentionally ignored.
  assign w_unused_wdata = ^bus.bus_wdata;

  always_comb begin
    w_ctrl_wdata         = '0;
    w_ctrl_wdata.en      = bus.bus_wdata[CTRL_EN_BIT];
    w_ctrl_wdata.ien     = bus.bus_wdata[CTRL_IEN_BIT];
    w_ctrl_wdata.oneshot = bus.bus_wdata[CTRL_ONESHOT_BIT];
    w_ctrl_wdata.pre     = bus.bus_wdata[CTRL_PRE_MSB:CTRL_PRE_LSB];
  end

  assign w_rd_chain[0] = '0;

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    logic [DWIDTH-1:0] w_chan_rdata;

    assign w_sel[c]      = w_chan_ok & (w_chan == AWIDTH'(c));
    assign w_ctrl_we[c]  = bus.bus_wr & w_sel[c] & (w_reg == REG_CTRL);
    assign w_mod_we[c]   = bus.bus_wr & w_sel[c] & (w_reg == REG_MOD);
    // FLAG clears via CTRL bit 15 on its own channel, or via any in-range STATUS write.
    assign w_flag_clr[c] = (w_ctrl_we[c] & bus.bus_wdata[CTRL_FLAG_BIT]) |
                           (w_status_we & bus.bus_wdata[c]);
    assign w_irq_d[c]    = w_flag[c] & w_ctrl[c].ien;

    pit_chan_core #(
      .COUNT_SIZE  (COUNT_SIZE),
      .NO_PRESCALE (NO_PRESCALE)
    ) u_core (
      .i_clk        (bus_clk),
      .i_rst_n      (async_rst_b),
      .i_sync_reset (sync_reset),
      .i_ctrl_we    (w_ctrl_we[c]),
      .i_ctrl_wdata (w_ctrl_wdata),
      .i_mod_we     (w_mod_we[c]),
      .i_mod_wdata  (w_mod_wdata),
      .i_flag_clr   (w_flag_clr[c]),
      .o_ctrl       (w_ctrl[c]),
      .o_mod        (w_mod[c]),
      .o_cnt        (w_cnt[c]),
      .o_flag       (w_flag[c])
    );

    always_comb begin
      w_chan_rdata = '0;
      if (w_sel[c]) begin
        case (w_reg)
          REG_CTRL: begin
            w_chan_rdata[CTRL_EN_BIT]               = w_ctrl[c].en;
            w_chan_rdata[CTRL_IEN_BIT]              = w_ctrl[c].ien;
            w_chan_rdata[CTRL_ONESHOT_BIT]          = w_ctrl[c].oneshot;
            w_chan_rdata[CTRL_PRE_MSB:CTRL_PRE_LSB] = w_ctrl[c].pre;
            w_chan_rdata[CTRL_FLAG_BIT]             = w_flag[c];
          end
          REG_MOD:    w_chan_rdata = DWIDTH'(w_mod[c]);
`ifdef PIT_CNT_READBACK_EN
          REG_CNT:    w_chan_rdata = DWIDTH'(w_cnt[c]);
`else
          REG_CNT:    w_chan_rdata = '0;
`endif
          REG_STATUS: w_chan_rdata = DWIDTH'(w_flag);
        endcase
      end
    end

`ifndef PIT_CNT_READBACK_EN
    logic w_unused_cnt;
    assign w_unused_cnt = ^w_cnt[c];
`endif

    // Only the selected channel drives non-zero, so an OR chain forms the read mux.
    assign w_rd_chain[c+1] = w_rd_chain[c] | w_chan_rdata;
  end

  always_ff @(posedge bus_clk or negedge async_rst_b) begin
    if (!async_rst_b) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_irq    <= '0;
    end else if (sync_reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_irq    <= '0;
    end else begin
      r_rvalid <= bus.bus_rd;
      if (bus.bus_rd) r_rdata <= w_rd_chain[NUM_CHAN];
      r_irq    <= w_irq_d;
    end
  end

  assign bus.bus_rdata  = r_rdata;
  assign bus.bus_rvalid = r_rvalid;
  assign irq_o          = r_irq;
  assign irq_any_o      = |r_irq;

endmodule
